multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, the single instruction/data memory port, the IR and the register file over several cycles per instruction.
- Drives alu_op into the existing ALU decoder, which stays unchanged. The decoder maps 00→add, 01→sub, 10→func3/func7 decode.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, jal. I-type ALU instructions are optional.

---
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The master side is the controller. The slave side is the datapath, or the testbench.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_op,
               illegal_op, state
    );

    modport slave (
        output op, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, reg_write, alu_op,
               illegal_op, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R-type, beq, jal).
// Define MULTICYCLE_CTRL_ITYPE_EN to add the I-type ALU path (EXECUTEI).
module multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       pc_update;
        logic       branch;
    } ctrl_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    ctrl_t      ctrl_reg;
    logic       wait_last;
    logic       op_known;

    // Moore outputs of a state. The strobes of the waited states fire only on
    // their final cycle.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic last);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.ir_write   = last;
                c.pc_update  = last;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = last;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
`ifdef MULTICYCLE_CTRL_ITYPE_EN
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
`endif
            S_ALUWB: c.reg_write = 1'b1;
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        op_known = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_R, OP_BEQ, OP_JAL: op_known = 1'b1;
`ifdef MULTICYCLE_CTRL_ITYPE_EN
            OP_I: op_known = 1'b1;
`endif
            default: op_known = 1'b0;
        endcase
    end

    assign wait_last = (cnt_reg == WAIT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (wait_last) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
`ifdef MULTICYCLE_CTRL_ITYPE_EN
                    OP_I:         state_next = S_EXECUTEI;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (wait_last) state_next = S_MEMWB;
            S_MEMWRITE: if (wait_last) state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
`ifdef MULTICYCLE_CTRL_ITYPE_EN
            S_EXECUTEI: state_next = S_ALUWB;
`endif
            S_JAL:      state_next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
        // The state only holds in a waited state, so the counter needs no other guard.
        cnt_next = (state_next == state_reg) ? cnt_reg + 4'd1 : 4'd0;
    end

    // The outputs are registered from the next state, so they line up with state_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            cnt_reg   <= 4'd0;
            ctrl_reg  <= decode_ctrl(S_FETCH, WAIT_LAST == 4'd0);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ctrl_reg  <= decode_ctrl(state_next, cnt_next == WAIT_LAST);
        end
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.imm_src = 2'b01;
            OP_BEQ:  bus.imm_src = 2'b10;
            OP_JAL:  bus.imm_src = 2'b11;
            default: bus.imm_src = 2'b00;
        endcase
    end

    assign bus.pc_write   = ctrl_reg.pc_update | (ctrl_reg.branch & bus.zero);
    assign bus.adr_src    = ctrl_reg.adr_src;
    assign bus.mem_write  = ctrl_reg.mem_write;
    assign bus.ir_write   = ctrl_reg.ir_write;
    assign bus.result_src = ctrl_reg.result_src;
    assign bus.alu_src_a  = ctrl_reg.alu_src_a;
    assign bus.alu_src_b  = ctrl_reg.alu_src_b;
    assign bus.reg_write  = ctrl_reg.reg_write;
    assign bus.alu_op     = ctrl_reg.alu_op;
    assign bus.illegal_op = (state_reg == S_DECODE) && !op_known;
    assign bus.state      = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Checks two controller instances, one with MEM_WAIT=0 and one with MEM_WAIT=2,
// against a reference model built from the instruction-level state paths.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n2;
    int   tests = 0;
    int   fails = 0;
    int   path_st[$];
    bit   path_last[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus0 ();
    multicycle_ctrl_if bus2 ();

    multicycle_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .rst_n(rst_n0), .bus(bus0.master));
    multicycle_ctrl #(.MEM_WAIT(2)) dut2 (.clk(clk), .rst_n(rst_n2), .bus(bus2.master));

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_known(input logic [6:0] o);
`ifdef MULTICYCLE_CTRL_ITYPE_EN
        return o == LW || o == SW || o == RT || o == BQ || o == JL || o == IT;
`else
        return o == LW || o == SW || o == RT || o == BQ || o == JL;
`endif
    endfunction

    // Adds a state to the path. The memory-port states last w+1 cycles.
    task automatic push_state(input int st, input int w);
        int n;
        n = (st == 0 || st == 3 || st == 5) ? w + 1 : 1;
        for (int k = 0; k < n; k++) begin
            path_st.push_back(st);
            path_last.push_back(k == n - 1);
        end
    endtask

    task automatic build_path(input logic [6:0] o, input int w);
        path_st.delete();
        path_last.delete();
        push_state(0, w);
        push_state(1, w);
        case (o)
            LW: begin push_state(2, w); push_state(3, w); push_state(4, w); end
            SW: begin push_state(2, w); push_state(5, w); end
            RT: begin push_state(6, w); push_state(7, w); end
            BQ: push_state(10, w);
            JL: begin push_state(9, w); push_state(7, w); end
`ifdef MULTICYCLE_CTRL_ITYPE_EN
            IT: begin push_state(8, w); push_state(7, w); end
`endif
            default: ;
        endcase
    endtask

    task automatic check_cycle(input int w, input int st, input bit last, input logic [6:0] o, input bit z);
        logic [3:0] a_st;
        logic a_pcw, a_adr, a_mw, a_ir, a_rw, a_ill;
        logic [1:0] a_res, a_sa, a_sb, a_imm, a_aop;
        logic e_pcw, e_adr, e_mw, e_ir, e_rw, e_ill;
        logic [1:0] e_res, e_sa, e_sb, e_imm, e_aop;
        if (w == 0) begin
            a_st = bus0.state; a_pcw = bus0.pc_write; a_adr = bus0.adr_src; a_mw = bus0.mem_write;
            a_ir = bus0.ir_write; a_rw = bus0.reg_write; a_ill = bus0.illegal_op; a_res = bus0.result_src;
            a_sa = bus0.alu_src_a; a_sb = bus0.alu_src_b; a_imm = bus0.imm_src; a_aop = bus0.alu_op;
        end else begin
            a_st = bus2.state; a_pcw = bus2.pc_write; a_adr = bus2.adr_src; a_mw = bus2.mem_write;
            a_ir = bus2.ir_write; a_rw = bus2.reg_write; a_ill = bus2.illegal_op; a_res = bus2.result_src;
            a_sa = bus2.alu_src_a; a_sb = bus2.alu_src_b; a_imm = bus2.imm_src; a_aop = bus2.alu_op;
        end
        {e_pcw, e_adr, e_mw, e_ir, e_rw} = '0;
        {e_res, e_sa, e_sb, e_aop} = '0;
        case (st)
            0:  begin e_sb = 2'b10; e_res = 2'b10; e_ir = last; e_pcw = last; end
            1:  begin e_sa = 2'b01; e_sb = 2'b01; end
            2:  begin e_sa = 2'b10; e_sb = 2'b01; end
            3:  e_adr = 1'b1;
            4:  begin e_res = 2'b01; e_rw = 1'b1; end
            5:  begin e_adr = 1'b1; e_mw = last; end
            6:  begin e_sa = 2'b10; e_aop = 2'b10; end
            7:  e_rw = 1'b1;
            8:  begin e_sa = 2'b10; e_sb = 2'b01; e_aop = 2'b10; end
            9:  begin e_sa = 2'b01; e_sb = 2'b10; e_pcw = 1'b1; end
            10: begin e_sa = 2'b10; e_aop = 2'b01; e_pcw = z; end
            default: ;
        endcase
        e_imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        e_ill = (st == 1) && !is_known(o);
        check("state", 32'(a_st), 32'(st));
        check("pc_write", 32'(a_pcw), 32'(e_pcw));
        check("adr_src", 32'(a_adr), 32'(e_adr));
        check("mem_write", 32'(a_mw), 32'(e_mw));
        check("ir_write", 32'(a_ir), 32'(e_ir));
        check("reg_write", 32'(a_rw), 32'(e_rw));
        check("result_src", 32'(a_res), 32'(e_res));
        check("alu_src_a", 32'(a_sa), 32'(e_sa));
        check("alu_src_b", 32'(a_sb), 32'(e_sb));
        check("alu_op", 32'(a_aop), 32'(e_aop));
        check("imm_src", 32'(a_imm), 32'(e_imm));
        check("illegal_op", 32'(a_ill), 32'(e_ill));
    endtask

    // zmode: 0/1 holds zero at that value, 2 randomises zero every cycle.
    task automatic run_instr(input int w, input logic [6:0] o, input int zmode);
        bit z;
        int f0;
        bus0.op = o;
        bus2.op = o;
        build_path(o, w);
        f0 = fails;
        for (int i = 0; i < path_st.size(); i++) begin
            z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            bus0.zero = z;
            bus2.zero = z;
            #1;
            check_cycle(w, path_st[i], path_last[i], o, z);
            @(negedge clk);
        end
        $display("[TB] dut_wait%0d op=%b zmode=%0d cycles=%0d errors=%0d", w, o, zmode, path_st.size(), fails - f0);
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] o;
        case ($urandom_range(0, 6))
            0: o = LW;
            1: o = SW;
            2: o = RT;
            3: o = BQ;
            4: o = JL;
            5: o = IT;
            default: begin
                o = 7'($urandom);
                if (o == LW || o == SW || o == RT || o == BQ || o == JL || o == IT) o = 7'b1111111;
            end
        endcase
        return o;
    endfunction

    initial begin
        rst_n0 = 1'b0;
        rst_n2 = 1'b0;
        bus0.op = 7'b0;  bus0.zero = 1'b0;
        bus2.op = 7'b0;  bus2.zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst0_state", 32'(bus0.state), 32'd0);
        check("rst0_ir_write", 32'(bus0.ir_write), 32'd1);
        check("rst0_pc_write", 32'(bus0.pc_write), 32'd1);
        check("rst0_alu_src_b", 32'(bus0.alu_src_b), 32'd2);
        check("rst0_result_src", 32'(bus0.result_src), 32'd2);
        check("rst2_ir_write", 32'(bus2.ir_write), 32'd0);
        check("rst2_pc_write", 32'(bus2.pc_write), 32'd0);
        @(negedge clk);
        rst_n0 = 1'b1;

        run_instr(0, LW, 2);
        run_instr(0, SW, 2);
        run_instr(0, RT, 2);
        run_instr(0, BQ, 1);
        run_instr(0, BQ, 0);
        run_instr(0, JL, 2);
        run_instr(0, 7'b1111111, 2);
        run_instr(0, IT, 2);

        // Reset arrives asynchronously in the middle of MEMREAD.
        bus0.op = LW;
        repeat (3) @(negedge clk);
        #1;
        check("pre_async_state", 32'(bus0.state), 32'd3);
        #1;
        rst_n0 = 1'b0;
        #1;
        check("async_rst_state", 32'(bus0.state), 32'd0);
        check("async_rst_ir_write", 32'(bus0.ir_write), 32'd1);
        $display("[TB] dut_wait0 async reset in MEMREAD");
        @(negedge clk);
        rst_n0 = 1'b1;

        repeat (40) run_instr(0, rand_op(), 2);

        rst_n0 = 1'b0;
        rst_n2 = 1'b1;
        run_instr(2, LW, 2);
        run_instr(2, SW, 2);
        run_instr(2, IT, 2);
        repeat (30) run_instr(2, rand_op(), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
